uart_rx_edge_bit_sampler: RTL and testbench
===========================================

// Module: uart_rx_edge_bit_sampler
// PURPOSE
//  Oversampling front end of the UART receiver, directly upstream of the receiver FSM.
//  Synchronises the raw RX line and counts oversampling edges inside each bit period.
//  Takes three samples around mid-bit and outputs their majority value as the received bit.
//  Supplies edge_count/edge_count_done to the FSM and sampled_bit to the start/parity/stop checkers and the deserializer.
// PARAMETERS
//  PRESCALE_WIDTH  6  width of prescale and edge_count; legal prescale values are 8, 16, 32
// PORTS
//  clk              input   1               system clock (oversampling rate)
//  reset            input   1               synchronous, active-high reset
//  enable           input   1               edge_counter_and_data_sampler_enable from the receiver FSM
//  prescale         input   PRESCALE_WIDTH  oversampling ratio (clk edges per UART bit)
//  serial_data_in   input   1               raw asynchronous RX line, idle high
//  serial_data_sync output  1               RX line after 2-FF synchroniser (feeds FSM IDLE start detect)
//  edge_count       output  PRESCALE_WIDTH  edge index within current bit, 0..prescale-1
//  edge_count_done  output  1               high while enable && edge_count == prescale_q-1
//  sampled_bit      output  1               majority-voted value of the last sampled bit
//  sample_valid     output  1               1-cycle pulse: sampled_bit was updated this cycle
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high and overrides everything, including mid-frame.
//  - Reset values:
//    - sync FFs = 1, serial_data_sync = 1
//    - edge_count = 0, edge_count_done = 0
//    - sampled_bit = 1, sample_valid = 0
//    - samples s0/s1/s2 = 1, prescale_q = 8
//  - Synchroniser: 2 flops. serial_data_sync lags serial_data_in by 2 cycles.
//    All sampling uses serial_data_sync only.
//  - prescale_q:
//    - loaded from prescale every cycle while enable=0; frozen while enable=1.
//    - prescale changes during a frame therefore take effect only at the next frame.
//    - prescale < 4 loads 4; values above 32 are unsupported.
//    - mid = prescale_q >> 1.
//  - Edge counter:
//    - enable=0: edge_count <= 0.
//    - enable=1 and edge_count == prescale_q-1: edge_count <= 0 (wrap).
//    - otherwise edge_count <= edge_count + 1.
//    - edge_count_done is combinational from the registered count and enable, so it is 0 whenever enable=0.
//  - Sampling (enable=1 only):
//    - s0 <= sync when edge_count == mid-1.
//    - s1 <= sync when edge_count == mid.
//    - s2 <= sync when edge_count == mid+1.
//  - Vote:
//    - In the cycle where edge_count == mid+1, a registered update follows.
//    - Next cycle: sampled_bit <= maj(s0, s1, sync) and sample_valid = 1 for exactly one cycle.
//    - Latency from the mid+1 edge to sample_valid is 1 cycle.
//  - At most one sample_valid per bit period. None while enable=0.
//  - enable dropping mid-bit:
//    - edge_count clears next cycle.
//    - Partial samples are discarded: the vote is suppressed and sampled_bit holds its value.
//  - enable rising: counting starts at edge 0 in that same cycle, using prescale_q loaded the previous cycle.
//  - Simultaneous wrap and re-enable is not possible. enable is an FSM state decode and holds across bit boundaries.
// TESTING
//  - Reset mid-count (prescale=8, edge_count=5, reset=1 one cycle)
//    -> next cycle edge_count=0, sampled_bit=1, sample_valid=0.
//  - prescale=8, enable held, sync line 0
//    -> edge_count 0..7 repeating; edge_count_done high at count 7 only;
//       sample_valid pulses the cycle after count 5 with sampled_bit=0.
//  - prescale=16, glitch: sync=1 only at edge 7, 0 at edges 8 and 9
//    -> sampled_bit=0 (majority).
//    Repeat with 1 at edges 7 and 9 -> sampled_bit=1.
//  - prescale=32, enable dropped at edge 15
//    -> no sample_valid, sampled_bit unchanged, edge_count=0 next cycle.
//  - prescale changed 8->16 while enable=1
//    -> count still wraps at 7 until enable falls; after re-enable it wraps at 15.
//  - Raw serial_data_in falls at cycle t
//    -> serial_data_sync falls at cycle t+2.
//    Also check prescale=2 -> behaves as prescale=4 (wrap at 3).

Source files
------------

// File: rtl/uart_rx_edge_bit_sampler.sv
// Oversampling front end of the UART receiver.
// Synchronises the raw RX line and counts oversampling edges within a bit.
// Around mid-bit it takes three samples and registers their majority as the
// received bit, flagging each fresh vote with a one-cycle sample_valid pulse.
module uart_rx_edge_bit_sampler #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      serial_data_in,
    output logic                      serial_data_sync,
    output logic [PRESCALE_WIDTH-1:0] edge_count,
    output logic                      edge_count_done,
    output logic                      sampled_bit,
    output logic                      sample_valid
);

    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_MIN = PRESCALE_WIDTH'(4);
    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_RST = PRESCALE_WIDTH'(8);
    localparam logic [PRESCALE_WIDTH-1:0] ONE          = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] ZERO         = PRESCALE_WIDTH'(0);

    // Two-of-three majority used for the mid-bit vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic                      sync_meta_r;
    logic                      sync_r;
    logic [PRESCALE_WIDTH-1:0] prescale_q_r;
    logic [PRESCALE_WIDTH-1:0] edge_count_r;
    logic                      s0_r;
    logic                      s1_r;
    logic                      s2_r;
    logic                      sampled_bit_r;
    logic                      sample_valid_r;

    logic [PRESCALE_WIDTH-1:0] mid_s;
    logic [PRESCALE_WIDTH-1:0] last_edge_s;
    logic [PRESCALE_WIDTH-1:0] prescale_load_s;
    logic                      at_s0_s;
    logic                      at_s1_s;
    logic                      at_s2_s;
    logic                      at_last_s;
    logic                      s2_next_s;

    // Decode the sample points and wrap point from the frozen prescale.
    always_comb begin
        mid_s       = {1'b0, prescale_q_r[PRESCALE_WIDTH-1:1]};
        last_edge_s = prescale_q_r - ONE;
        at_s0_s     = enable && (edge_count_r == (mid_s - ONE));
        at_s1_s     = enable && (edge_count_r == mid_s);
        at_s2_s     = enable && (edge_count_r == (mid_s + ONE));
        at_last_s   = enable && (edge_count_r == last_edge_s);
        if (prescale < PRESCALE_MIN) begin
            prescale_load_s = PRESCALE_MIN;
        end else begin
            prescale_load_s = prescale;
        end
        // The third sample is voted in the same edge it is captured, so the
        // vote uses the live synchronised value rather than the stored s2.
        if (at_s2_s) begin
            s2_next_s = sync_r;
        end else begin
            s2_next_s = s2_r;
        end
    end

    // Two-flop synchroniser for the asynchronous RX line (idle high).
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_r <= 1'b1;
            sync_r      <= 1'b1;
        end else begin
            sync_meta_r <= serial_data_in;
            sync_r      <= sync_meta_r;
        end
    end

    // Track prescale between frames; freeze it for the whole enabled period.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q_r <= PRESCALE_RST;
        end else if (!enable) begin
            prescale_q_r <= prescale_load_s;
        end else begin
            prescale_q_r <= prescale_q_r;
        end
    end

    // Edge counter: cleared while idle, wraps at the end of each bit period.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_count_r <= ZERO;
        end else if (!enable) begin
            edge_count_r <= ZERO;
        end else if (at_last_s) begin
            edge_count_r <= ZERO;
        end else begin
            edge_count_r <= edge_count_r + ONE;
        end
    end

    // Capture the three samples around mid-bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_r <= 1'b1;
            s1_r <= 1'b1;
            s2_r <= 1'b1;
        end else begin
            s0_r <= at_s0_s ? sync_r : s0_r;
            s1_r <= at_s1_s ? sync_r : s1_r;
            s2_r <= s2_next_s;
        end
    end

    // Register the majority vote one cycle after the last sample point.
    always_ff @(posedge clk) begin
        if (reset) begin
            sampled_bit_r  <= 1'b1;
            sample_valid_r <= 1'b0;
        end else if (at_s2_s) begin
            sampled_bit_r  <= maj3(s0_r, s1_r, s2_next_s);
            sample_valid_r <= 1'b1;
        end else begin
            sampled_bit_r  <= sampled_bit_r;
            sample_valid_r <= 1'b0;
        end
    end

    assign serial_data_sync = sync_r;
    assign edge_count       = edge_count_r;
    assign edge_count_done  = at_last_s;
    assign sampled_bit      = sampled_bit_r;
    assign sample_valid     = sample_valid_r;

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Self-checking bench for uart_rx_edge_bit_sampler: directed scenarios with
// literal expectations plus a randomized run, all compared each cycle against
// a behavioural model built from sample lists and modular arithmetic.
module tb_uart_rx_edge_bit_sampler;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [5:0] prescale;
    logic       serial_data_in;
    logic       serial_data_sync;
    logic [5:0] edge_count;
    logic       edge_count_done;
    logic       sampled_bit;
    logic       sample_valid;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int m_pipe [2];   // [0] = synchronised line, [1] = first flop
    int m_smp  [3];   // samples at mid-1, mid, mid+1
    int m_cnt;
    int m_psq;
    int m_bit;
    int m_valid;

    uart_rx_edge_bit_sampler #(.PRESCALE_WIDTH(6)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .prescale         (prescale),
        .serial_data_in   (serial_data_in),
        .serial_data_sync (serial_data_sync),
        .edge_count       (edge_count),
        .edge_count_done  (edge_count_done),
        .sampled_bit      (sampled_bit),
        .sample_valid     (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int old_sync;
        int mid;
        int ones;
        old_sync = m_pipe[0];
        if (reset) begin
            m_pipe  = '{1, 1};
            m_smp   = '{1, 1, 1};
            m_cnt   = 0;
            m_bit   = 1;
            m_valid = 0;
            m_psq   = 8;
        end else begin
            m_pipe  = '{m_pipe[1], int'(serial_data_in)};
            m_valid = 0;
            if (enable) begin
                mid = m_psq / 2;
                if (m_cnt >= mid - 1 && m_cnt <= mid + 1)
                    m_smp[m_cnt - (mid - 1)] = old_sync;
                if (m_cnt == mid + 1) begin
                    ones    = m_smp[0] + m_smp[1] + m_smp[2];
                    m_bit   = (ones >= 2) ? 1 : 0;
                    m_valid = 1;
                end
                m_cnt = (m_cnt + 1) % m_psq;
            end else begin
                m_cnt = 0;
                m_psq = (int'(prescale) < 4) ? 4 : int'(prescale);
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cyc();
        int exp_done;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_done = (enable && (m_cnt == m_psq - 1)) ? 1 : 0;
        chk("m_sync",  int'(serial_data_sync), m_pipe[0]);
        chk("m_count", int'(edge_count),       m_cnt);
        chk("m_done",  int'(edge_count_done),  exp_done);
        chk("m_bit",   int'(sampled_bit),      m_bit);
        chk("m_valid", int'(sample_valid),     m_valid);
    endtask

    // Pre-roll two idle cycles so the synchronised line equals want[e] at edge e,
    // then run n enabled cycles.
    task automatic frame_bit(input int ps, input logic [31:0] want, input int n);
        enable   = 1'b0;
        prescale = 6'(ps);
        serial_data_in = want[0];
        cyc();
        serial_data_in = want[1];
        cyc();
        enable = 1'b1;
        for (int k = 0; k < n; k++) begin
            serial_data_in = (k + 2 < 32) ? want[k + 2] : 1'b1;
            cyc();
        end
    endtask

    initial begin
        logic [31:0] pat;
        int          hold_ps;
        reset = 1'b1; enable = 1'b0; prescale = 6'd8; serial_data_in = 1'b1;
        m_pipe = '{1, 1}; m_smp = '{1, 1, 1};
        m_cnt = 0; m_psq = 8; m_bit = 1; m_valid = 0;
        @(negedge clk);
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_count", int'(edge_count), 0);
        chk("rst_bit",   int'(sampled_bit), 1);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_sync",  int'(serial_data_sync), 1);
        chk("rst_done",  int'(edge_count_done), 0);

        // raw line falls: synchronised output follows two edges later
        serial_data_in = 1'b0;
        cyc();
        chk("sync_lag1", int'(serial_data_sync), 1);
        cyc();
        chk("sync_lag2", int'(serial_data_sync), 0);

        // prescale 8, line low: count 0..7, done at 7, vote after count 5
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("p8_count", int'(edge_count), i % 8);
            chk("p8_done",  int'(edge_count_done), (i % 8 == 7) ? 1 : 0);
            chk("p8_valid", int'(sample_valid), (i % 8 == 6) ? 1 : 0);
            if (i % 8 == 6) chk("p8_bit", int'(sampled_bit), 0);
            cyc();
        end

        // reset mid-count at edge 5
        for (int i = 0; i < 5; i++) cyc();
        chk("pre_rst_count", int'(edge_count), 5);
        reset = 1'b1;
        cyc();
        reset = 1'b0; enable = 1'b0;
        chk("mid_rst_count", int'(edge_count), 0);
        chk("mid_rst_bit",   int'(sampled_bit), 1);
        chk("mid_rst_valid", int'(sample_valid), 0);

        // prescale 16 glitch: only edge 7 high -> 0
        pat = 32'h0000_0080;
        frame_bit(16, pat, 10);
        chk("g1_valid", int'(sample_valid), 1);
        chk("g1_bit",   int'(sampled_bit), 0);
        // edges 7 and 9 high, edge 8 low -> 1
        pat = 32'h0000_0280;
        frame_bit(16, pat, 10);
        chk("g2_valid", int'(sample_valid), 1);
        chk("g2_bit",   int'(sampled_bit), 1);

        // prescale 32, enable dropped while count shows 15
        pat = 32'h0000_0000;
        frame_bit(32, pat, 15);
        chk("p32_count15", int'(edge_count), 15);
        enable = 1'b0;
        cyc();
        chk("p32_count", int'(edge_count), 0);
        chk("p32_valid", int'(sample_valid), 0);
        chk("p32_bit",   int'(sampled_bit), 1);
        for (int i = 0; i < 4; i++) cyc();

        // prescale 8 -> 16 mid-frame takes effect only after re-enable
        pat = 32'hFFFF_FFFF;
        frame_bit(8, pat, 0);
        prescale = 6'd16;
        for (int i = 0; i < 16; i++) begin
            chk("chg_count8", int'(edge_count), i % 8);
            cyc();
        end
        enable = 1'b0;
        cyc();
        cyc();
        enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("chg_count16", int'(edge_count), i % 16);
            chk("chg_done16",  int'(edge_count_done), (i % 16 == 15) ? 1 : 0);
            cyc();
        end

        // prescale 2 clamps to 4
        frame_bit(2, pat, 0);
        for (int i = 0; i < 12; i++) begin
            chk("p2_count", int'(edge_count), i % 4);
            chk("p2_done",  int'(edge_count_done), (i % 4 == 3) ? 1 : 0);
            chk("p2_valid", int'(sample_valid), (i > 0 && i % 4 == 0) ? 1 : 0);
            cyc();
        end
        enable = 1'b0;
        cyc();

        // randomized run against the model
        hold_ps = 8;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 4))
                    0: hold_ps = 2;
                    1: hold_ps = 4;
                    2: hold_ps = 8;
                    3: hold_ps = 16;
                    default: hold_ps = 32;
                endcase
            end
            prescale = 6'(hold_ps);
            if ($urandom_range(0, 5) == 0) serial_data_in = ~serial_data_in;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
